// File: rtl/rv32v_uop_sequencer_if.sv
// Decode-to-execute bundle for the vector micro-op sequencer.
// master = sequencer side, slave = decode/execute environment side.
interface rv32v_uop_sequencer_if #(
    parameter int MAX_VL = 128,
    parameter int OFF_W  = $clog2(MAX_VL)
);
    logic              start;
    logic              start_ready;
    logic [31:0]       vl;
    logic [OFF_W-1:0]  vstart;
    logic              vm;
    logic [MAX_VL-1:0] v0_mask;
    logic              flush;
    logic              uop_valid;
    logic              uop_ready;
    logic [OFF_W-1:0]  woffset0;
    logic [OFF_W-1:0]  woffset1;
    logic              wen0;
    logic              wen1;
    logic              mask0;
    logic              mask1;
    logic              uop_last;

    modport master (
        input  start, vl, vstart, vm, v0_mask, flush, uop_ready,
        output start_ready, uop_valid, woffset0, woffset1,
               wen0, wen1, mask0, mask1, uop_last
    );

    modport slave (
        output start, vl, vstart, vm, v0_mask, flush, uop_ready,
        input  start_ready, uop_valid, woffset0, woffset1,
               wen0, wen1, mask0, mask1, uop_last
    );
endinterface

// File: rtl/rv32v_uop_sequencer.sv
// Splits one decoded vector instruction into two-lane element micro-ops.
// Optional RV32V_UOP_SKIP_EN: fully masked pairs are consumed internally without being presented.
//
// state | meaning
// IDLE  | waiting for start, start_ready=1
// RUN   | presenting micro-ops, counter steps by 2 per accepted pair
module rv32v_uop_sequencer #(
    parameter int MAX_VL = 128,
    parameter int OFF_W  = $clog2(MAX_VL)
) (
    input  logic                  CLK,
    input  logic                  RST,
    rv32v_uop_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done
);
    // Two extra bits so counter+2 and eff_vl=MAX_VL never wrap.
    localparam int CW = OFF_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic             valid;
        logic [OFF_W-1:0] woff0;
        logic [OFF_W-1:0] woff1;
        logic             wen0;
        logic             wen1;
        logic             mask0;
        logic             mask1;
        logic             last;
    } uop_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     eff_q;
    logic              vm_q;
    logic [MAX_VL-1:0] mask_q;
    uop_t              uop_q;

    logic [CW-1:0]     eff_in;
    logic [CW-1:0]     vstart_ext;
    logic [CW-1:0]     cnt_step;
    logic              advance;

    function automatic uop_t calc_uop(input logic [CW-1:0]     c,
                                      input logic [CW-1:0]     eff,
                                      input logic [MAX_VL-1:0] msk,
                                      input logic              vmv);
        uop_t          u;
        logic [CW-1:0] e1;
        logic          in0;
        logic          in1;
        e1      = c + CW'(1);
        in0     = c < eff;
        in1     = e1 < eff;
        u.woff0 = c[OFF_W-1:0];
        u.woff1 = e1[OFF_W-1:0];
        u.mask0 = in0 & msk[c[OFF_W-1:0]];
        u.mask1 = in1 & msk[e1[OFF_W-1:0]];
        u.wen0  = in0 & (vmv | u.mask0);
        u.wen1  = in1 & (vmv | u.mask1);
        u.last  = (c + CW'(2)) >= eff;
`ifdef RV32V_UOP_SKIP_EN
        u.valid = vmv | u.wen0 | u.wen1;
`else
        u.valid = 1'b1;
`endif
        return u;
    endfunction

    // Clamp at full 32-bit width before narrowing.
    assign eff_in     = (bus.vl > 32'(MAX_VL)) ? CW'(MAX_VL) : bus.vl[CW-1:0];
    assign vstart_ext = CW'(bus.vstart);
    assign cnt_step   = cnt + CW'(2);

`ifdef RV32V_UOP_SKIP_EN
    assign advance = !uop_q.valid || bus.uop_ready;
`else
    assign advance = bus.uop_ready;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            eff_q  <= '0;
            vm_q   <= 1'b0;
            mask_q <= '0;
            uop_q  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        if (eff_in > vstart_ext) begin
                            state  <= RUN;
                            cnt    <= vstart_ext;
                            eff_q  <= eff_in;
                            vm_q   <= bus.vm;
                            mask_q <= bus.v0_mask;
                            uop_q  <= calc_uop(vstart_ext, eff_in, bus.v0_mask, bus.vm);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        uop_q <= '0;
                    end else if (advance) begin
                        if (uop_q.last) begin
                            state <= IDLE;
                            uop_q <= '0;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= cnt_step;
                            uop_q <= calc_uop(cnt_step, eff_q, mask_q, vm_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy            = (state == RUN);
    assign bus.start_ready = !busy;
    assign bus.uop_valid   = uop_q.valid;
    assign bus.woffset0    = uop_q.woff0;
    assign bus.woffset1    = uop_q.woff1;
    assign bus.wen0        = uop_q.wen0;
    assign bus.wen1        = uop_q.wen1;
    assign bus.mask0       = uop_q.mask0;
    assign bus.mask1       = uop_q.mask1;
    assign bus.uop_last    = uop_q.last;
endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Bench for rv32v_uop_sequencer: element-level reference model, directed and random scenarios.
module tb_rv32v_uop_sequencer;
    logic CLK = 1'b0;
    logic RST;
    logic busy;
    logic done;

    rv32v_uop_sequencer_if #(.MAX_VL(128), .OFF_W(7)) bus ();

    rv32v_uop_sequencer #(.MAX_VL(128), .OFF_W(7)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus.master),
        .busy (busy),
        .done (done)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [6:0] o0;
        logic [6:0] o1;
        logic       w0;
        logic       w1;
        logic       m0;
        logic       m1;
        logic       l;
    } uop_rec_t;

    int errors = 0;
    int checks = 0;

    uop_rec_t exp_q[$];
    uop_rec_t obs_q[$];
    int exp_pairs;
    int done_iter;
    int valid_cycles;
    int stall_cycles;
    int hold_breaks;
    bit busy_at_done;
    bit sr_at_done;
    bit done_after;

    // Reference: walk elements in pairs from vstart up to the clamped length.
    task automatic model_build(input logic [31:0] vl_i, input int vs_i, input bit vm_i,
                               input logic [127:0] m_i);
        int eff;
        uop_rec_t r;
        bit in1;
        bit skip;
        exp_q.delete();
        exp_pairs = 0;
        eff = (vl_i > 128) ? 128 : int'(vl_i);
        for (int e = vs_i; e < eff; e += 2) begin
            in1  = (e + 1) < eff;
            r.o0 = 7'(e);
            r.o1 = 7'((e + 1) % 128);
            r.m0 = m_i[e];
            r.m1 = in1 ? m_i[e+1] : 1'b0;
            r.w0 = vm_i || r.m0;
            r.w1 = in1 && (vm_i || r.m1);
            r.l  = (e + 2 >= eff);
            skip = 1'b0;
`ifdef RV32V_UOP_SKIP_EN
            skip = !vm_i && !r.w0 && !r.w1;
`endif
            if (!skip) exp_q.push_back(r);
            exp_pairs++;
        end
    endtask

    function automatic uop_rec_t sample_uop();
        uop_rec_t r;
        r.o0 = bus.woffset0;
        r.o1 = bus.woffset1;
        r.w0 = bus.wen0;
        r.w1 = bus.wen1;
        r.m0 = bus.mask0;
        r.m1 = bus.mask1;
        r.l  = bus.uop_last;
        return r;
    endfunction

    // mode 0: ready always, 1: random ready, 2: stall 3 cycles on second micro-op while poking start
    task automatic run_seq(input logic [31:0] vl_i, input int vs_i, input bit vm_i,
                           input logic [127:0] m_i, input int mode);
        int acc;
        int stall_n;
        bit rdy;
        bit prev_stalled;
        uop_rec_t cur;
        uop_rec_t prev;
        obs_q.delete();
        done_iter = -1; valid_cycles = 0; stall_cycles = 0; hold_breaks = 0;
        busy_at_done = 1'b1; sr_at_done = 1'b0; done_after = 1'b1;
        acc = 0; stall_n = 0; prev_stalled = 1'b0; prev = '0;
        @(negedge CLK);
        bus.start = 1'b1; bus.vl = vl_i; bus.vstart = 7'(vs_i);
        bus.vm = vm_i; bus.v0_mask = m_i; bus.uop_ready = 1'b0;
        @(negedge CLK);
        bus.start = 1'b0;
        for (int iter = 0; iter < 600; iter++) begin
            cur = sample_uop();
            if (done) begin
                done_iter = iter;
                busy_at_done = busy;
                sr_at_done = bus.start_ready;
                break;
            end
            if (prev_stalled && (!bus.uop_valid || cur !== prev)) hold_breaks++;
            if (bus.uop_valid) begin
                valid_cycles++;
                case (mode)
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    2:       rdy = !(acc == 1 && stall_n < 3);
                    default: rdy = 1'b1;
                endcase
                bus.uop_ready = rdy;
                bus.start = (mode == 2) && !rdy;
                if (rdy) begin
                    obs_q.push_back(cur);
                    acc++;
                end else begin
                    stall_cycles++;
                    stall_n++;
                end
                prev_stalled = !rdy;
                prev = cur;
            end else begin
                bus.uop_ready = 1'($urandom_range(0, 1));
                bus.start = 1'b0;
                prev_stalled = 1'b0;
            end
            @(negedge CLK);
        end
        bus.uop_ready = 1'b0;
        bus.start = 1'b0;
        @(negedge CLK);
        done_after = done;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.start = 1'b0; bus.vl = '0; bus.vstart = '0; bus.vm = 1'b0;
        bus.v0_mask = '0; bus.flush = 1'b0; bus.uop_ready = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.uop_valid, busy, done, bus.start_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0001", {bus.uop_valid, busy, done, bus.start_ready});
        end
        checks++;
        if ({bus.woffset0, bus.woffset1, bus.wen0, bus.wen1, bus.mask0, bus.mask1, bus.uop_last} !== 19'd0) begin
            errors++;
            $display("FAIL reset_lanes: got %h expected 0",
                     {bus.woffset0, bus.woffset1, bus.wen0, bus.wen1, bus.mask0, bus.mask1, bus.uop_last});
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        model_build(32'd8, 0, 1'b1, '0);
        run_seq(32'd8, 0, 1'b1, '0, 0);
        checks++;
        if (obs_q.size() !== 4) begin
            errors++; $display("FAIL basic_count: got %0d expected 4", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL basic_uop[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_iter !== 4 || done_after !== 1'b0) begin
            errors++; $display("FAIL basic_done: got iter %0d after %b expected iter 4 after 0", done_iter, done_after);
        end
        checks++;
        if ({busy_at_done, sr_at_done} !== 2'b01) begin
            errors++; $display("FAIL basic_idle_at_done: got %b expected 01", {busy_at_done, sr_at_done});
        end
    endtask

    task automatic test_masked();
        model_build(32'd5, 1, 1'b0, 128'b10110);
        run_seq(32'd5, 1, 1'b0, 128'b10110, 0);
        checks++;
        if (obs_q.size() !== 2) begin
            errors++; $display("FAIL masked_count: got %0d expected 2", obs_q.size());
        end else begin
            checks++;
            if ({obs_q[0].o0, obs_q[0].w0, obs_q[0].w1, obs_q[1].o0, obs_q[1].w0, obs_q[1].w1, obs_q[1].l}
                !== {7'd1, 2'b11, 7'd3, 3'b011}) begin
                errors++; $display("FAIL masked_pairs: got %h %h expected (1,wen 11) (3,wen 01,last)", obs_q[0], obs_q[1]);
            end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL masked_uop[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        model_build(32'd4, 0, 1'b1, '0);
        run_seq(32'd4, 0, 1'b1, '0, 2);
        checks++;
        if (obs_q.size() !== 2 || stall_cycles !== 3) begin
            errors++; $display("FAIL bp_count: got %0d accepts %0d stalls expected 2 and 3", obs_q.size(), stall_cycles);
        end
        checks++;
        if (hold_breaks !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d changes while stalled expected 0", hold_breaks);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_uop[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_iter !== 5) begin
            errors++; $display("FAIL bp_done: got iter %0d expected 5", done_iter);
        end
    endtask

    task automatic test_empty();
        logic [31:0] vls [2] = '{32'd0, 32'd6};
        int          vss [2] = '{0, 6};
        for (int k = 0; k < 2; k++) begin
            run_seq(vls[k], vss[k], 1'b1, '1, 0);
            checks++;
            if (valid_cycles !== 0 || done_iter !== 0 || sr_at_done !== 1'b1 || done_after !== 1'b0) begin
                errors++;
                $display("FAIL empty_%0d: got valid %0d done_iter %0d ready %b after %b expected 0 0 1 0",
                         k, valid_cycles, done_iter, sr_at_done, done_after);
            end
        end
    endtask

    task automatic test_clamp();
        model_build(32'd300, 0, 1'b1, '0);
        run_seq(32'd300, 0, 1'b1, '0, 0);
        checks++;
        if (obs_q.size() !== 64) begin
            errors++; $display("FAIL clamp_count: got %0d expected 64", obs_q.size());
        end else begin
            checks++;
            if ({obs_q[63].o0, obs_q[63].o1, obs_q[63].l, obs_q[62].l} !== {7'd126, 7'd127, 2'b10}) begin
                errors++; $display("FAIL clamp_last: got %h expected (126,127) last", obs_q[63]);
            end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL clamp_uop[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_flush();
        int acc = 0;
        bit flushed = 1'b0;
        @(negedge CLK);
        bus.start = 1'b1; bus.vl = 32'd10; bus.vstart = 7'd0; bus.vm = 1'b1; bus.uop_ready = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        for (int i = 0; i < 10 && !flushed; i++) begin
            if (bus.uop_valid) begin
                if (acc == 2) begin
                    checks++;
                    if (bus.woffset0 !== 7'd4) begin
                        errors++; $display("FAIL flush_third: got %0d expected 4", bus.woffset0);
                    end
                    bus.flush = 1'b1;
                    flushed = 1'b1;
                end
                acc++;
            end
            @(negedge CLK);
        end
        bus.flush = 1'b0;
        checks++;
        if ({flushed, bus.uop_valid, busy, done, bus.start_ready} !== 5'b10001) begin
            errors++; $display("FAIL flush_idle: got %b expected 10001", {flushed, bus.uop_valid, busy, done, bus.start_ready});
        end
        bus.uop_ready = 1'b0;
        @(negedge CLK);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL flush_no_done: got %b expected 0", done);
        end
        bus.start = 1'b1; bus.flush = 1'b1; bus.vl = 32'd4; bus.vstart = 7'd0;
        @(negedge CLK);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++;
        if ({bus.uop_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL flush_in_idle: got %b expected 000", {bus.uop_valid, busy, done});
        end
        run_seq(32'd2, 0, 1'b1, '0, 0);
        checks++;
        if (obs_q.size() !== 1 || done_iter !== 1) begin
            errors++; $display("FAIL flush_restart: got %0d uops done_iter %0d expected 1 1", obs_q.size(), done_iter);
        end
    endtask

    task automatic test_midreset();
        @(negedge CLK);
        bus.start = 1'b1; bus.vl = 32'd20; bus.vstart = 7'd0; bus.vm = 1'b1; bus.uop_ready = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({bus.uop_valid, busy, done, bus.start_ready} !== 4'b0001) begin
            errors++; $display("FAIL midreset: got %b expected 0001", {bus.uop_valid, busy, done, bus.start_ready});
        end
        @(negedge CLK);
        bus.uop_ready = 1'b0;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL midreset_no_done: got %b expected 00", {done, busy});
        end
    endtask

    task automatic test_skip();
        model_build(32'd6, 0, 1'b0, 128'b110011);
        run_seq(32'd6, 0, 1'b0, 128'b110011, 0);
`ifdef RV32V_UOP_SKIP_EN
        checks++;
        if (obs_q.size() !== 2) begin
            errors++; $display("FAIL skip_count: got %0d expected 2", obs_q.size());
        end else begin
            checks++;
            if ({obs_q[0].o0, obs_q[1].o0} !== {7'd0, 7'd4}) begin
                errors++; $display("FAIL skip_offsets: got %0d,%0d expected 0,4", obs_q[0].o0, obs_q[1].o0);
            end
        end
`else
        checks++;
        if (obs_q.size() !== 3) begin
            errors++; $display("FAIL noskip_count: got %0d expected 3", obs_q.size());
        end else begin
            checks++;
            if ({obs_q[1].o0, obs_q[1].w0, obs_q[1].w1} !== {7'd2, 2'b00}) begin
                errors++; $display("FAIL noskip_pair: got %h expected offset 2 wen 00", obs_q[1]);
            end
        end
`endif
        checks++;
        if (done_iter !== 3) begin
            errors++; $display("FAIL skip_done: got iter %0d expected 3", done_iter);
        end
    endtask

    task automatic test_random();
        logic [31:0]  vl_r;
        int           vs_r;
        bit           vm_r;
        logic [127:0] m_r;
        for (int n = 0; n < 24; n++) begin
            vl_r = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 140));
            vs_r = $urandom_range(0, 127);
            if ($urandom_range(0, 1) == 1 && vl_r < 128) vs_r = $urandom_range(0, int'(vl_r));
            if (vs_r > 127) vs_r = 127;
            vm_r = 1'($urandom_range(0, 1));
            m_r  = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_build(vl_r, vs_r, vm_r, m_r);
            run_seq(vl_r, vs_r, vm_r, m_r, 1);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d expected %0d (vl %0d vstart %0d vm %b)",
                         n, obs_q.size(), exp_q.size(), vl_r, vs_r, vm_r);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_uop[%0d]: got %h expected %h", n, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (done_iter !== exp_pairs + stall_cycles || hold_breaks !== 0 || done_after !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_timing: got done_iter %0d holdbreaks %0d after %b expected %0d 0 0",
                         n, done_iter, hold_breaks, done_after, exp_pairs + stall_cycles);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_backpressure();
        test_empty();
        test_clamp();
        test_flush();
        test_midreset();
        test_skip();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
